// File: rtl/timer_regs_pkg.sv
// Register map of the interval-timer slave and FSM state encoding of its tick master.
package timer_regs_pkg;

  localparam logic [2:0] TMR_ADDR_STATUS  = 3'd0;
  localparam logic [2:0] TMR_ADDR_CONTROL = 3'd1;
  localparam logic [2:0] TMR_ADDR_PERIODL = 3'd2;
  localparam logic [2:0] TMR_ADDR_PERIODH = 3'd3;

  localparam int unsigned STATUS_TO   = 0;
  localparam int unsigned STATUS_RUN  = 1;
  localparam int unsigned CONTROL_ITO = 0;

  typedef enum logic [2:0] {
    StIdle,
    StWrCtrl,
    StIrqWait,
    StRdStat,
    StRdWait,
    StGap,
    StWrClr,
    StWrDis
  } tmr_state_e;

endpackage

// File: rtl/timer_tick_master.sv
// Avalon-MM initiator that arms the interval timer, detects each timeout, clears it and
// emits a one-cycle tick plus a wrapping tick count.
module timer_tick_master
  import timer_regs_pkg::*;
#(
  parameter bit          USE_IRQ      = 1'b1,
  parameter int unsigned POLL_GAP     = 0,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic [15:0] tmr_readdata,
  input  logic        tmr_irq,
  output logic        tick,
  output logic [15:0] tick_count,
  output logic        busy
);

  localparam logic [7:0] LatInit = 8'(READ_LATENCY);
  localparam logic [7:0] GapInit = 8'(POLL_GAP);

  tmr_state_e  r_state, w_state_d;
  logic [7:0]  r_cnt, w_cnt_d;
  logic        r_cs, w_cs_d;
  logic        r_wn, w_wn_d;
  logic [2:0]  r_addr, w_addr_d;
  logic [15:0] r_wd, w_wd_d;
  logic        r_tick, w_tick_d;
  logic [15:0] r_tick_count, w_tick_count_d;

  // Only the TO bit is ever consumed.
  logic w_unused_rdata;
  assign w_unused_rdata = ^tmr_readdata[15:1];

  // Next-state logic; the shared counter times both read latency and poll gap.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (enable) w_state_d = StWrCtrl;
      end
      StWrCtrl: begin
        if (USE_IRQ) w_state_d = StIrqWait;
        else         w_state_d = StRdStat;
      end
      StIrqWait: begin
        if (!enable)      w_state_d = StWrDis;
        else if (tmr_irq) w_state_d = StRdStat;
      end
      StRdStat: begin
        w_cnt_d   = LatInit;
        w_state_d = StRdWait;
      end
      StRdWait: begin
        if (r_cnt > 8'd1) begin
          w_cnt_d = r_cnt - 8'd1;
        end else begin
          // readdata is valid in this cycle
          w_cnt_d = 8'd0;
          if (tmr_readdata[STATUS_TO]) begin
            w_state_d = StWrClr;
          end else if (!enable) begin
            w_state_d = StWrDis;
          end else if (USE_IRQ) begin
            w_state_d = StIrqWait;
          end else if (POLL_GAP != 0) begin
            w_state_d = StGap;
            w_cnt_d   = GapInit;
          end else begin
            w_state_d = StRdStat;
          end
        end
      end
      StGap: begin
        if (!enable) begin
          w_state_d = StWrDis;
          w_cnt_d   = 8'd0;
        end else if (r_cnt <= 8'd1) begin
          w_state_d = StRdStat;
          w_cnt_d   = 8'd0;
        end else begin
          w_cnt_d = r_cnt - 8'd1;
        end
      end
      StWrClr: begin
        if (!enable)      w_state_d = StWrDis;
        else if (USE_IRQ) w_state_d = StIrqWait;
        else              w_state_d = StRdStat;
      end
      StWrDis: begin
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Bus and tick outputs decoded from the next state so they line up with the state register.
  always_comb begin
    w_cs_d   = 1'b0;
    w_wn_d   = 1'b1;
    w_addr_d = TMR_ADDR_STATUS;
    w_wd_d   = 16'h0000;
    w_tick_d = 1'b0;
    unique case (w_state_d)
      StWrCtrl: begin
        w_cs_d              = 1'b1;
        w_wn_d              = 1'b0;
        w_addr_d            = TMR_ADDR_CONTROL;
        w_wd_d[CONTROL_ITO] = 1'b1;
      end
      StRdStat: begin
        w_cs_d = 1'b1;
      end
      StWrClr: begin
        w_cs_d   = 1'b1;
        w_wn_d   = 1'b0;
        w_tick_d = 1'b1;
      end
      StWrDis: begin
        w_cs_d   = 1'b1;
        w_wn_d   = 1'b0;
        w_addr_d = TMR_ADDR_CONTROL;
      end
      default: ;
    endcase
    w_tick_count_d = r_tick_count;
    if (w_tick_d) w_tick_count_d = r_tick_count + 16'd1;
  end

  // State, counter and registered bus outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_cnt        <= 8'd0;
      r_cs         <= 1'b0;
      r_wn         <= 1'b1;
      r_addr       <= 3'd0;
      r_wd         <= 16'h0000;
      r_tick       <= 1'b0;
      r_tick_count <= 16'h0000;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_cs         <= w_cs_d;
      r_wn         <= w_wn_d;
      r_addr       <= w_addr_d;
      r_wd         <= w_wd_d;
      r_tick       <= w_tick_d;
      r_tick_count <= w_tick_count_d;
    end
  end

  assign tmr_address    = r_addr;
  assign tmr_chipselect = r_cs;
  assign tmr_write_n    = r_wn;
  assign tmr_writedata  = r_wd;
  assign tick           = r_tick;
  assign tick_count     = r_tick_count;
  assign busy           = (r_state != StIdle);

endmodule

// File: tb/tb_timer_tick_master.sv
// Directed bench for timer_tick_master: a cycle table on a poll-mode instance plus
// hand-written sequences on irq-mode and poll-gap instances.
module tb_timer_tick_master;

  // {chipselect, write_n, address, writedata}
  localparam logic [20:0] B_IDLE  = {1'b0, 1'b1, 3'd0, 16'h0000};
  localparam logic [20:0] B_WCTRL = {1'b1, 1'b0, 3'd1, 16'h0001};
  localparam logic [20:0] B_RD    = {1'b1, 1'b1, 3'd0, 16'h0000};
  localparam logic [20:0] B_WCLR  = {1'b1, 1'b0, 3'd0, 16'h0000};
  localparam logic [20:0] B_WDIS  = {1'b1, 1'b0, 3'd1, 16'h0000};
  localparam int NV = 33;

  typedef struct {
    logic        en;
    logic        to;
    logic [20:0] bus;
    logic        tick;
    logic        busy;
    logic [15:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Poll-mode instance, latency 1, no gap.
  logic        pl_rst_n, pl_en, pl_cs, pl_wn, pl_tick, pl_busy, pl_to, pl_use_model;
  logic [2:0]  pl_addr;
  logic [15:0] pl_wd, pl_rd, pl_cnt;
  logic [20:0] pl_bus;

  // Timer slave model with a 20-cycle period.
  logic        m_run = 1'b0;
  logic        m_to;
  logic [4:0]  m_cnt;
  logic [15:0] m_rd;

  assign pl_bus = {pl_cs, pl_wn, pl_addr, pl_wd};
  assign pl_rd  = pl_use_model ? m_rd : {15'd0, pl_to};

  always @(posedge clk) begin
    if (!m_run) begin
      m_cnt <= '0;
      m_to  <= 1'b0;
    end else begin
      if (pl_cs && !pl_wn && pl_addr == 3'd0) m_to <= 1'b0;
      if (m_cnt == 5'd19) begin
        m_cnt <= '0;
        m_to  <= 1'b1;
      end else begin
        m_cnt <= m_cnt + 5'd1;
      end
    end
    m_rd <= {14'd0, m_run, m_to};
  end

  timer_tick_master #(.USE_IRQ(1'b0), .POLL_GAP(0), .READ_LATENCY(1)) u_poll (
    .clk(clk), .reset_n(pl_rst_n), .enable(pl_en), .tmr_address(pl_addr),
    .tmr_chipselect(pl_cs), .tmr_write_n(pl_wn), .tmr_writedata(pl_wd),
    .tmr_readdata(pl_rd), .tmr_irq(1'b0), .tick(pl_tick), .tick_count(pl_cnt),
    .busy(pl_busy)
  );

  // Irq-mode instance, latency 2.
  logic        iq_rst_n, iq_en, iq_cs, iq_wn, iq_tick, iq_busy, iq_to, iq_irq;
  logic        iq_rd1, iq_rd2;
  logic [2:0]  iq_addr;
  logic [15:0] iq_wd, iq_cnt, iq_rd;
  logic [20:0] iq_bus;
  assign iq_bus = {iq_cs, iq_wn, iq_addr, iq_wd};
  assign iq_rd  = {15'd0, iq_rd2};
  always @(posedge clk) begin
    iq_rd1 <= iq_to;
    iq_rd2 <= iq_rd1;
  end

  timer_tick_master #(.USE_IRQ(1'b1), .POLL_GAP(0), .READ_LATENCY(2)) u_irq (
    .clk(clk), .reset_n(iq_rst_n), .enable(iq_en), .tmr_address(iq_addr),
    .tmr_chipselect(iq_cs), .tmr_write_n(iq_wn), .tmr_writedata(iq_wd),
    .tmr_readdata(iq_rd), .tmr_irq(iq_irq), .tick(iq_tick), .tick_count(iq_cnt),
    .busy(iq_busy)
  );

  // Poll-mode instance with a 3-cycle gap; status always reads TO=0.
  logic        gp_rst_n, gp_en, gp_cs, gp_wn, gp_tick, gp_busy;
  logic [2:0]  gp_addr;
  logic [15:0] gp_wd, gp_cnt;
  logic [20:0] gp_bus;
  assign gp_bus = {gp_cs, gp_wn, gp_addr, gp_wd};

  timer_tick_master #(.USE_IRQ(1'b0), .POLL_GAP(3), .READ_LATENCY(1)) u_gap (
    .clk(clk), .reset_n(gp_rst_n), .enable(gp_en), .tmr_address(gp_addr),
    .tmr_chipselect(gp_cs), .tmr_write_n(gp_wn), .tmr_writedata(gp_wd),
    .tmr_readdata(16'h0000), .tmr_irq(1'b0), .tick(gp_tick), .tick_count(gp_cnt),
    .busy(gp_busy)
  );

  vec_t vecs [NV];
  int   last_rd, sp_err, n_tk, set_cyc, n_act, n_rd;
  int   rds [4];
  bit   tick_since;
  logic prev_to;
  logic [15:0] start_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] expv(input logic [20:0] bus, input logic tk, input logic bz,
                                       input logic [15:0] cnt);
    return 64'({bus, tk, bz, cnt});
  endfunction

  function automatic logic [63:0] obs_pl();
    return 64'({pl_bus, pl_tick, pl_busy, pl_cnt});
  endfunction

  function automatic logic [63:0] obs_iq();
    return 64'({iq_bus, iq_tick, iq_busy, iq_cnt});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // {en, to, bus, tick, busy, tick_count} after the edge that follows the row's inputs
    vecs[0]  = '{1'b0, 1'b0, B_IDLE,  1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 1'b0, B_WCTRL, 1'b0, 1'b1, 16'd0};
    vecs[2]  = '{1'b1, 1'b0, B_RD,    1'b0, 1'b1, 16'd0};
    vecs[3]  = '{1'b1, 1'b1, B_IDLE,  1'b0, 1'b1, 16'd0};
    vecs[4]  = '{1'b1, 1'b0, B_RD,    1'b0, 1'b1, 16'd0};
    vecs[5]  = '{1'b1, 1'b0, B_IDLE,  1'b0, 1'b1, 16'd0};
    vecs[6]  = '{1'b1, 1'b1, B_WCLR,  1'b1, 1'b1, 16'd1};
    vecs[7]  = '{1'b1, 1'b1, B_RD,    1'b0, 1'b1, 16'd1};
    vecs[8]  = '{1'b1, 1'b1, B_IDLE,  1'b0, 1'b1, 16'd1};
    vecs[9]  = '{1'b0, 1'b0, B_WDIS,  1'b0, 1'b1, 16'd1};
    vecs[10] = '{1'b0, 1'b0, B_IDLE,  1'b0, 1'b0, 16'd1};
    vecs[11] = '{1'b0, 1'b1, B_IDLE,  1'b0, 1'b0, 16'd1};
    vecs[12] = '{1'b1, 1'b0, B_WCTRL, 1'b0, 1'b1, 16'd1};
    vecs[13] = '{1'b1, 1'b0, B_RD,    1'b0, 1'b1, 16'd1};
    vecs[14] = '{1'b1, 1'b0, B_IDLE,  1'b0, 1'b1, 16'd1};
    vecs[15] = '{1'b0, 1'b1, B_WCLR,  1'b1, 1'b1, 16'd2};
    vecs[16] = '{1'b0, 1'b0, B_WDIS,  1'b0, 1'b1, 16'd2};
    vecs[17] = '{1'b0, 1'b0, B_IDLE,  1'b0, 1'b0, 16'd2};
    vecs[18] = '{1'b1, 1'b0, B_WCTRL, 1'b0, 1'b1, 16'd2};
    vecs[19] = '{1'b0, 1'b0, B_RD,    1'b0, 1'b1, 16'd2};
    vecs[20] = '{1'b0, 1'b0, B_IDLE,  1'b0, 1'b1, 16'd2};
    vecs[21] = '{1'b0, 1'b0, B_WDIS,  1'b0, 1'b1, 16'd2};
    vecs[22] = '{1'b0, 1'b0, B_IDLE,  1'b0, 1'b0, 16'd2};
    vecs[23] = '{1'b1, 1'b0, B_WCTRL, 1'b0, 1'b1, 16'd2};
    vecs[24] = '{1'b1, 1'b0, B_RD,    1'b0, 1'b1, 16'd2};
    vecs[25] = '{1'b1, 1'b0, B_IDLE,  1'b0, 1'b1, 16'd2};
    vecs[26] = '{1'b0, 1'b0, B_WDIS,  1'b0, 1'b1, 16'd2};
    vecs[27] = '{1'b1, 1'b0, B_IDLE,  1'b0, 1'b0, 16'd2};
    vecs[28] = '{1'b1, 1'b0, B_WCTRL, 1'b0, 1'b1, 16'd2};
    vecs[29] = '{1'b0, 1'b0, B_RD,    1'b0, 1'b1, 16'd2};
    vecs[30] = '{1'b0, 1'b0, B_IDLE,  1'b0, 1'b1, 16'd2};
    vecs[31] = '{1'b0, 1'b0, B_WDIS,  1'b0, 1'b1, 16'd2};
    vecs[32] = '{1'b0, 1'b0, B_IDLE,  1'b0, 1'b0, 16'd2};

    pl_rst_n = 1'b0; iq_rst_n = 1'b0; gp_rst_n = 1'b0;
    pl_en = 1'b0; pl_to = 1'b0; pl_use_model = 1'b0;
    iq_en = 1'b0; iq_to = 1'b0; iq_irq = 1'b0; gp_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset poll", obs_pl(), expv(B_IDLE, 1'b0, 1'b0, 16'd0));
    check("reset irq", obs_iq(), expv(B_IDLE, 1'b0, 1'b0, 16'd0));
    check("reset gap", 64'({gp_bus, gp_busy}), 64'({B_IDLE, 1'b0}));
    pl_rst_n = 1'b1; iq_rst_n = 1'b1; gp_rst_n = 1'b1;

    // Cycle table on the poll instance.
    for (int i = 0; i < NV; i++) begin
      pl_en = vecs[i].en;
      pl_to = vecs[i].to;
      step();
      check($sformatf("vec%0d", i), obs_pl(),
            expv(vecs[i].bus, vecs[i].tick, vecs[i].busy, vecs[i].cnt));
    end

    // Reset while waiting for read data, with enable held.
    pl_en = 1'b1; pl_to = 1'b0;
    step(); step(); step();
    check("pre-reset rdwait", obs_pl(), expv(B_IDLE, 1'b0, 1'b1, 16'd2));
    pl_rst_n = 1'b0;
    #1;
    check("async reset", obs_pl(), expv(B_IDLE, 1'b0, 1'b0, 16'd0));
    step();
    pl_rst_n = 1'b1;
    step();
    check("rearm after reset", obs_pl(), expv(B_WCTRL, 1'b0, 1'b1, 16'd0));
    pl_en = 1'b0;
    for (int k = 0; k < 10 && pl_busy; k++) step();
    check("poll stop after reset", 64'(pl_busy), 64'd0);

    // tick_count wrap: preload 0xFFFF, then take ticks with TO forced high.
    force u_poll.r_tick_count = 16'hFFFF;
    step();
    release u_poll.r_tick_count;
    check("preload", 64'(pl_cnt), 64'h0000_FFFF);
    pl_en = 1'b1; pl_to = 1'b1;
    step(); step(); step(); step();
    check("wrap tick", obs_pl(), expv(B_WCLR, 1'b1, 1'b1, 16'h0000));
    step(); step(); step();
    check("post-wrap tick", obs_pl(), expv(B_WCLR, 1'b1, 1'b1, 16'h0001));
    pl_en = 1'b0;
    step();
    check("wrap disarm", obs_pl(), expv(B_WDIS, 1'b0, 1'b1, 16'h0001));
    pl_to = 1'b0;
    step();
    check("wrap idle", obs_pl(), expv(B_IDLE, 1'b0, 1'b0, 16'h0001));

    // Poll against the 20-cycle slave model for five periods.
    start_cnt = pl_cnt;
    last_rd = -1; tick_since = 1'b0; sp_err = 0; n_tk = 0; set_cyc = 0; prev_to = 1'b0;
    pl_use_model = 1'b1; m_run = 1'b1; pl_en = 1'b1;
    for (int k = 0; k < 110; k++) begin
      step();
      if (m_to && !prev_to) set_cyc = cyc;
      prev_to = m_to;
      if (pl_tick) begin
        n_tk++;
        check("model tick write", 64'(pl_bus), 64'(B_WCLR));
        check("model tick latency", 64'((cyc - set_cyc) <= 4), 64'd1);
        tick_since = 1'b1;
      end
      if (pl_cs && pl_wn) begin
        if (last_rd >= 0 && (cyc - last_rd) != (tick_since ? 3 : 2)) sp_err++;
        last_rd = cyc;
        tick_since = 1'b0;
      end
    end
    pl_en = 1'b0;
    for (int k = 0; k < 10 && pl_busy; k++) step();
    check("model stop", 64'(pl_busy), 64'd0);
    check("model read spacing errors", 64'(sp_err), 64'd0);
    check("model tick pulses", 64'(n_tk), 64'd5);
    check("model tick_count delta", 64'(16'(pl_cnt - start_cnt)), 64'd5);
    m_run = 1'b0; pl_use_model = 1'b0;

    // Irq mode: quiet while irq low, then a real timeout and a spurious irq.
    iq_en = 1'b1;
    step();
    check("irq arm", obs_iq(), expv(B_WCTRL, 1'b0, 1'b1, 16'd0));
    step();
    check("irq wait", obs_iq(), expv(B_IDLE, 1'b0, 1'b1, 16'd0));
    n_act = 0;
    for (int k = 0; k < 95; k++) begin
      step();
      if (iq_cs) n_act++;
    end
    check("irq quiet bus", 64'(n_act), 64'd0);
    iq_to = 1'b1; iq_irq = 1'b1;
    step();
    check("irq read", obs_iq(), expv(B_RD, 1'b0, 1'b1, 16'd0));
    step();
    check("irq rdwait1", obs_iq(), expv(B_IDLE, 1'b0, 1'b1, 16'd0));
    step();
    check("irq rdwait2", obs_iq(), expv(B_IDLE, 1'b0, 1'b1, 16'd0));
    step();
    check("irq tick", obs_iq(), expv(B_WCLR, 1'b1, 1'b1, 16'd1));
    iq_to = 1'b0; iq_irq = 1'b0;
    step(); step(); step();
    check("irq rewait", obs_iq(), expv(B_IDLE, 1'b0, 1'b1, 16'd1));
    iq_irq = 1'b1;
    step();
    check("spurious read", obs_iq(), expv(B_RD, 1'b0, 1'b1, 16'd1));
    iq_irq = 1'b0;
    step(); step(); step(); step();
    check("spurious no tick", obs_iq(), expv(B_IDLE, 1'b0, 1'b1, 16'd1));
    iq_en = 1'b0; iq_irq = 1'b1;
    step();
    check("irq disable priority", obs_iq(), expv(B_WDIS, 1'b0, 1'b1, 16'd1));
    iq_irq = 1'b0;
    step();
    check("irq idle", obs_iq(), expv(B_IDLE, 1'b0, 1'b0, 16'd1));

    // Poll gap of 3: read-issue cycles are 5 apart; enable drop in GAP disarms at once.
    gp_en = 1'b1;
    n_rd = 0;
    for (int k = 0; k < 40 && n_rd < 4; k++) begin
      step();
      if (gp_cs && gp_wn) begin
        rds[n_rd] = cyc;
        n_rd++;
      end
    end
    check("gap reads seen", 64'(n_rd), 64'd4);
    for (int i = 1; i < 4; i++) check($sformatf("gap spacing%0d", i), 64'(rds[i] - rds[i-1]), 64'd5);
    step(); step();
    gp_en = 1'b0;
    step();
    check("gap disarm", 64'({gp_bus, gp_busy}), 64'({B_WDIS, 1'b1}));
    step();
    check("gap idle", 64'({gp_bus, gp_busy, gp_tick, gp_cnt}), 64'({B_IDLE, 1'b0, 1'b0, 16'd0}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
